input_conditioner: RTL and testbench

//   Upstream stage of the sequence-detector FSM. Takes the four raw, asynchronous

---
 rtl/input_conditioner_if.sv | 32 +++
 rtl/input_conditioner.sv | 114 +++++++++++
 tb/tb_input_conditioner.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/input_conditioner_if.sv
// Bundle between the raw input pins and the sequence detector:
// raw codes in, debounced code plus edge/change strobes out.
interface input_conditioner_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] raw_in;
    logic [WIDTH-1:0] clean_out;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic             change;
    logic             settled;

    // Producer of raw inputs, consumer of the conditioned code
    modport master (
        output raw_in,
        input  clean_out,
        input  rise,
        input  fall,
        input  change,
        input  settled
    );

    // The conditioner itself
    modport slave (
        input  raw_in,
        output clean_out,
        output rise,
        output fall,
        output change,
        output settled
    );
endinterface

// File: rtl/input_conditioner.sv
// Two-flop synchroniser plus per-channel debounce counter.
// Emits a clean code with registered rise/fall/change pulses.
module input_conditioner #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 3
) (
    input  logic                clk,
    input  logic                reset,
    input_conditioner_if.slave  bus
);

    typedef enum logic {
        STABLE  = 1'b0,
        PENDING = 1'b1
    } ch_state_e;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] clean_q, clean_d;
    logic [WIDTH-1:0] rise_q,  rise_d;
    logic [WIDTH-1:0] fall_q,  fall_d;
    logic             change_q, change_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    ch_state_e        st_w [WIDTH];
    logic             settled_w;

    // Channel state is implied by whether sync2 disagrees with the clean code
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            st_w[i] = (sync2_q[i] != clean_q[i]) ? PENDING : STABLE;
        end
    end

    // Next-state: synchroniser shift and per-channel debounce decisions
    always_comb begin
        sync1_d = bus.raw_in;
        sync2_d = sync1_q;
        clean_d = clean_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
        end
        for (int i = 0; i < WIDTH; i++) begin
            unique case (st_w[i])
                STABLE: begin
                    cnt_d[i] = '0;
                end
                PENDING: begin
                    if (cnt_q[i] == LAST) begin
                        clean_d[i] = sync2_q[i];
                        rise_d[i]  = sync2_q[i];
                        fall_d[i]  = ~sync2_q[i];
                        cnt_d[i]   = '0;
                    end else begin
                        cnt_d[i]   = cnt_q[i] + ONE;
                    end
                end
                default: begin
                    cnt_d[i] = '0;
                end
            endcase
        end
        change_d = |(rise_d | fall_d);
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            clean_q  <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            change_q <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            clean_q  <= clean_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            change_q <= change_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Quiet when no channel is mid-count and every sync2 matches clean
    always_comb begin
        settled_w = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            if (st_w[i] == PENDING || cnt_q[i] != '0) begin
                settled_w = 1'b0;
            end
        end
    end

    assign bus.clean_out = clean_q;
    assign bus.rise      = rise_q;
    assign bus.fall      = fall_q;
    assign bus.change    = change_q;
    assign bus.settled   = settled_w;

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: vector table, directed corner cases,
// and random traffic against a window-based debounce model.
module tb_input_conditioner;

    localparam int W = 4;
    localparam int D = 4;

    logic clk;
    logic reset;

    input_conditioner_if #(.WIDTH(W)) bus ();
    input_conditioner_if #(.WIDTH(W)) bus1 ();

    input_conditioner #(
        .WIDTH(W), .DEBOUNCE_CYCLES(D), .CNT_W(3)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus.slave)
    );

    input_conditioner #(
        .WIDTH(W), .DEBOUNCE_CYCLES(1), .CNT_W(1)
    ) dut1 (
        .clk(clk), .reset(reset), .bus(bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: clean flips when the last D synchronised
    // samples all disagree with it.
    logic [W-1:0] rawq   [$];
    logic [W-1:0] s2hist [$];
    logic [W-1:0] m_clean, m_rise, m_fall;
    logic         m_change, m_settled;

    task automatic model_reset();
        rawq.delete();
        s2hist.delete();
        rawq.push_back('0);
        rawq.push_back('0);
        for (int j = 0; j < D; j++) s2hist.push_back('0);
        m_clean = '0; m_rise = '0; m_fall = '0;
        m_change = 1'b0; m_settled = 1'b1;
    endtask

    task automatic model_edge(input logic rst, input logic [W-1:0] raw);
        logic [W-1:0] s2, s2now, nc;
        logic flip;
        if (rst) begin
            model_reset();
            return;
        end
        rawq.push_back(raw);
        s2 = rawq[rawq.size()-3];
        s2hist.push_back(s2);
        nc = m_clean;
        m_rise = '0; m_fall = '0;
        for (int b = 0; b < W; b++) begin
            flip = 1'b1;
            for (int j = 0; j < D; j++)
                if (s2hist[s2hist.size()-1-j][b] == m_clean[b]) flip = 1'b0;
            if (flip) begin
                nc[b] = s2[b];
                m_rise[b] = s2[b];
                m_fall[b] = ~s2[b];
            end
        end
        m_clean = nc;
        m_change = |(m_rise | m_fall);
        s2now = rawq[rawq.size()-2];
        m_settled = 1'b1;
        for (int b = 0; b < W; b++)
            if (s2now[b] != m_clean[b] || s2[b] != m_clean[b]) m_settled = 1'b0;
        while (rawq.size() > 8) void'(rawq.pop_front());
        while (s2hist.size() > 8) void'(s2hist.pop_front());
    endtask

    // One clock edge; the model is stepped and every output compared
    task automatic tick();
        logic r;
        logic [W-1:0] rv;
        r  = reset;
        rv = bus.raw_in;
        @(posedge clk);
        #1;
        model_edge(r, rv);
        check("m_clean",   32'(bus.clean_out), 32'(m_clean));
        check("m_rise",    32'(bus.rise),      32'(m_rise));
        check("m_fall",    32'(bus.fall),      32'(m_fall));
        check("m_change",  32'(bus.change),    32'(m_change));
        check("m_settled", 32'(bus.settled),   32'(m_settled));
    endtask

    typedef struct {
        logic         rst;
        logic [W-1:0] raw;
        logic [W-1:0] clean;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
        logic         chg;
        logic         set;
    } vec_t;

    vec_t vecs [$];

    task automatic add(input logic rst, input logic [W-1:0] raw,
                       input logic [W-1:0] cl, input logic [W-1:0] ri,
                       input logic [W-1:0] fa, input logic ch,
                       input logic st, input int n);
        vec_t v;
        v.rst = rst; v.raw = raw; v.clean = cl; v.rise = ri;
        v.fall = fa; v.chg = ch; v.set = st;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    int rise_cnt, fall_cnt, rise_at;

    initial begin
        reset = 1'b1;
        bus.raw_in  = '0;
        bus1.raw_in = '0;
        model_reset();

        // Reset hold with raw 0100, release, latency 6
        add(1, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 0, 1, 3);
        add(0, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 0, 1, 1);
        add(0, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 0, 0, 4);
        add(0, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 1, 1, 1);
        add(0, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 0, 1, 2);
        // Simultaneous i1+i4 rise then fall
        add(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 1, 1);
        add(0, 4'b1001, 4'b0000, 4'b0000, 4'b0000, 0, 1, 1);
        add(0, 4'b1001, 4'b0000, 4'b0000, 4'b0000, 0, 0, 4);
        add(0, 4'b1001, 4'b1001, 4'b1001, 4'b0000, 1, 1, 1);
        add(0, 4'b1001, 4'b1001, 4'b0000, 4'b0000, 0, 1, 2);
        add(0, 4'b0000, 4'b1001, 4'b0000, 4'b0000, 0, 1, 1);
        add(0, 4'b0000, 4'b1001, 4'b0000, 4'b0000, 0, 0, 4);
        add(0, 4'b0000, 4'b0000, 4'b0000, 4'b1001, 1, 1, 1);
        add(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 1, 2);

        foreach (vecs[i]) begin
            reset = vecs[i].rst;
            bus.raw_in = vecs[i].raw;
            tick();
            check("tab_clean",  32'(bus.clean_out), 32'(vecs[i].clean));
            check("tab_rise",   32'(bus.rise),      32'(vecs[i].rise));
            check("tab_fall",   32'(bus.fall),      32'(vecs[i].fall));
            check("tab_change", 32'(bus.change),    32'(vecs[i].chg));
            check("tab_settle", 32'(bus.settled),   32'(vecs[i].set));
        end

        // 3-cycle glitch on i1 is rejected
        reset = 1'b1; bus.raw_in = '0; tick();
        reset = 1'b0;
        for (int t = 0; t < 12; t++) begin
            bus.raw_in = (t < 3) ? 4'b0001 : 4'b0000;
            tick();
            check("glitch_clean",  32'(bus.clean_out), 32'd0);
            check("glitch_rise",   32'(bus.rise),      32'd0);
            check("glitch_change", 32'(bus.change),    32'd0);
        end
        check("glitch_settled", 32'(bus.settled), 32'd1);

        // i3 chatters every 2 cycles, then held high
        reset = 1'b1; bus.raw_in = '0; tick();
        reset = 1'b0;
        rise_cnt = 0; fall_cnt = 0; rise_at = -1;
        for (int t = 0; t < 25; t++) begin
            bus.raw_in = (t >= 10 || ((t / 2) % 2 == 0)) ? 4'b0100 : 4'b0000;
            tick();
            if (bus.rise[2]) begin rise_cnt++; rise_at = t; end
            if (bus.fall[2]) fall_cnt++;
        end
        check("chatter_rises", 32'(rise_cnt), 32'd1);
        check("chatter_falls", 32'(fall_cnt), 32'd0);
        check("chatter_edge",  32'(rise_at),  32'd13);

        // Reset mid-count discards progress
        reset = 1'b1; bus.raw_in = '0; tick();
        reset = 1'b0; bus.raw_in = 4'b0010;
        for (int t = 1; t <= 4; t++) begin
            tick();
            check("midrst_pre", 32'(bus.clean_out), 32'd0);
        end
        reset = 1'b1; tick();
        check("midrst_clean", 32'(bus.clean_out), 32'd0);
        check("midrst_sett",  32'(bus.settled),   32'd1);
        reset = 1'b0;
        for (int t = 1; t <= 5; t++) begin
            tick();
            check("midrst_early", 32'({bus.clean_out, bus.rise}), 32'd0);
        end
        tick();
        check("midrst_rise",  32'(bus.rise),      32'b0010);
        check("midrst_clean", 32'(bus.clean_out), 32'b0010);
        check("midrst_chg",   32'(bus.change),    32'd1);

        // DEBOUNCE_CYCLES=1 instance: latency 3, glitches pass
        reset = 1'b1; bus.raw_in = '0; tick();
        reset = 1'b0; bus1.raw_in = 4'b0001;
        tick(); tick();
        check("d1_early", 32'(bus1.clean_out), 32'd0);
        tick();
        check("d1_clean", 32'(bus1.clean_out), 32'b0001);
        check("d1_rise",  32'(bus1.rise),      32'b0001);
        check("d1_chg",   32'(bus1.change),    32'd1);
        tick();
        check("d1_rise_end", 32'(bus1.rise), 32'd0);
        bus1.raw_in = 4'b0011; tick();
        bus1.raw_in = 4'b0001; tick(); tick();
        check("d1_glitch_rise", 32'(bus1.rise), 32'b0010);
        tick();
        check("d1_glitch_fall", 32'(bus1.fall),      32'b0010);
        check("d1_glitch_cl",   32'(bus1.clean_out), 32'b0001);
        bus1.raw_in = '0;

        // Random traffic against the model
        reset = 1'b1; tick();
        reset = 1'b0;
        for (int t = 0; t < 3000; t++) begin
            logic [W-1:0] tog;
            tog = '0;
            for (int b = 0; b < W; b++)
                tog[b] = ($urandom_range(0, 5) == 0);
            bus.raw_in = bus.raw_in ^ tog;
            reset = ($urandom_range(0, 199) == 0);
            tick();
        end
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
